// File: rtl/aes_ct_stream_rx_if.sv
`default_nettype none
// ============================================================================
// aes_ct_stream_rx_if : byte stream, expected block and checker result bundle
// Rev 1.0
// ============================================================================
interface aes_ct_stream_rx_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       din;
    logic             din_vld;
    logic [127:0]     exp_text;
    logic [127:0]     blk_out;
    logic             blk_done;
    logic             match;
    logic             timeout_err;
    logic             ovr_err;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output din, din_vld, exp_text,
        input  blk_out, blk_done, match, timeout_err, ovr_err, busy,
               pass_cnt, fail_cnt
    );

    modport slave (
        input  din, din_vld, exp_text,
        output blk_out, blk_done, match, timeout_err, ovr_err, busy,
               pass_cnt, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/aes_ct_stream_rx.sv
`default_nettype none
// ============================================================================
// aes_ct_stream_rx : assembles 16 ciphertext bytes, compares with expected text
// Rev 1.0
// ============================================================================
module aes_ct_stream_rx #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_,
    aes_ct_stream_rx_if.slave bus
);
    localparam int GAP_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [119:0]     shreg;
    logic [127:0]     exp_q;
    logic [127:0]     blk_q;
    logic             match_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;

    logic             accept;
    logic             tmo;
    logic             done;
    logic             ovr;
    logic [127:0]     assembled;

    // The 16th byte completes the block in the same cycle it is accepted, so
    // blk_out/match are already valid while the FSM sits in CMP.
    assign assembled = {shreg, bus.din};

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo       = 1'b0;
        done      = 1'b0;
        ovr       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.din_vld) begin
                    accept    = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (bus.din_vld) begin
                    accept = 1'b1;
                    if (byte_cnt == 4'd15) state_nxt = CMP;
                end else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CMP: begin
                done      = 1'b1;
                ovr       = bus.din_vld;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            byte_cnt <= 4'd0;
            gap_cnt  <= '0;
            shreg    <= '0;
            exp_q    <= '0;
            blk_q    <= '0;
            match_q  <= 1'b0;
        end else if (accept) begin
            shreg   <= assembled[119:0];
            gap_cnt <= '0;
            if (state == IDLE) begin
                byte_cnt <= 4'd1;
                exp_q    <= bus.exp_text;
            end else begin
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (state == RECV && byte_cnt == 4'd15) begin
                blk_q   <= assembled;
                match_q <= (assembled == exp_q);
            end
        end else if (tmo) begin
            gap_cnt  <= '0;
            byte_cnt <= 4'd0;
        end else if (state == RECV) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pass_q <= '0;
            fail_q <= '0;
        end else begin
            if (done && match_q && pass_q != {CNT_W{1'b1}})
                pass_q <= pass_q + CNT_W'(1);
            if (((done && !match_q) || tmo) && fail_q != {CNT_W{1'b1}})
                fail_q <= fail_q + CNT_W'(1);
        end
    end

    assign bus.blk_out     = blk_q;
    assign bus.match       = match_q;
    assign bus.blk_done    = done;
    assign bus.timeout_err = tmo;
    assign bus.ovr_err     = ovr;
    assign bus.busy        = (state != IDLE);
    assign bus.pass_cnt    = pass_q;
    assign bus.fail_cnt    = fail_q;
endmodule
`default_nettype wire
